booth_pp_accumulator: RTL and testbench
=======================================

// Module: booth_pp_accumulator
// PURPOSE
//   Sequential partial-product reducer placed directly downstream of Booth_Encoder.
//   Accepts the eight 32-bit Booth partial products (PP1..PP8) with a valid/ready handshake.
//   Sums them into a 32-bit two's-complement product over NUM_PP/PP_PER_CYCLE cycles.
//   Presents the product on a registered valid/ready output port.
// PARAMETERS
//   WIDTH        32  width of each partial product, the accumulator and the product
//   PP_PER_CYCLE 1   partial products added per ACCUM cycle; legal values are 1, 2, 4 and 8.
//                    Any other value is an elaboration error.
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      PP1..PP8 are valid
//   in_ready   out  1      block can accept an operand set
//   PP1..PP8   in   WIDTH  partial products, one port each, taken from Booth_Encoder
//   out_valid  out  1      product is valid
//   out_ready  in   1      consumer accepts the product
//   product    out  WIDTH  PP1+PP2+...+PP8, modulo 2^WIDTH
//   busy       out  1      high in ACCUM or DONE
// BEHAVIOUR
//   Reset
//     - rst sampled high at a rising edge forces state=IDLE, acc=0, cnt=0, out_valid=0, product=0.
//     - in_ready reads 1 in the cycle after reset is released.
//     - Reset mid-ACCUM or mid-DONE aborts the operation: no out_valid pulse, the result is lost.
//   FSM states: IDLE, ACCUM, DONE
//     - IDLE: in_ready=1. On in_valid&&in_ready:
//         - register PP1..PP8 into an internal bank
//         - acc<=0, cnt<=0, state<=ACCUM
//     - ACCUM: in_ready=0. Each cycle:
//         - add registered PPs [cnt*K .. cnt*K+K-1] into acc (K=PP_PER_CYCLE)
//         - cnt<=cnt+1
//         - on the last group (cnt==8/K-1), state<=DONE
//     - DONE: out_valid=1 and product=acc, held stable until out_ready.
//         - On out_valid&&out_ready: state<=IDLE, out_valid<=0.
//   Latency: out_valid goes high exactly 8/K clock edges after the accepting edge.
//     - K=1 gives 8 edges; K=8 gives 1 edge.
//   Throughput: at most one operand set per 8/K+2 cycles.
//     - There is no accept in the same cycle as the output handshake.
//   Input port outside IDLE:
//     - in_valid is ignored in ACCUM and DONE.
//     - PP inputs may change freely after acceptance; only the registered bank is used.
//   Arithmetic:
//     - All adds are WIDTH-bit and wrap modulo 2^WIDTH; no overflow flag.
//     - For 16x16 signed operands the true product always fits in 32 bits.
//   Back-pressure: while out_ready=0, product and out_valid do not change and nothing else is accepted.
//   Simultaneous rst and handshake: rst wins.
// TESTING
//   Drive PP1..PP8 from a Booth_Encoder instance; compare product against $signed(M)*$signed(Q).
//   T1  M=18, Q=999, K=1, out_ready=1 -> product=17982 (0x0000463E).
//       out_valid high 8 edges after accept, for exactly 1 cycle.
//   T2  M=-2311, Q=11111 -> product=-25677521.
//       M=16'hFFFF, Q=16'hFFFF -> product=1.
//       M=16'h7FFF, Q=16'h7FFF -> product=0x3FFF0001.
//       M=16'h8000, Q=16'h8000 -> product=0x40000000.
//   T3  Hold out_ready=0 for 5 cycles in DONE -> out_valid and product stay constant, in_ready=0.
//       in_valid pulses during this time are not accepted.
//   T4  Assert rst for 1 cycle on the 4th ACCUM cycle -> next cycle: in_ready=1, out_valid=0, product=0.
//       A new operand set (M=1, Q=11111) then yields 11111.
//   T5  Rebuild with K=2 and with K=8 -> latency 4 and 1 edges respectively.
//       Results match T1/T2 bit-exactly.
//   T6  Random stress: 1000 random M,Q with random in_valid/out_ready gaps -> zero mismatches.
//       No dropped or duplicated results.

Source files
------------

// File: rtl/booth_pp_accumulator_if.sv
// Operand/result bundle between Booth_Encoder, the partial-product accumulator and its consumer.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface booth_pp_accumulator_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] pp1;
    logic [WIDTH-1:0] pp2;
    logic [WIDTH-1:0] pp3;
    logic [WIDTH-1:0] pp4;
    logic [WIDTH-1:0] pp5;
    logic [WIDTH-1:0] pp6;
    logic [WIDTH-1:0] pp7;
    logic [WIDTH-1:0] pp8;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] product;
    logic             busy;

    modport master (
        output in_valid,
        output pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Sequential reducer for the eight Booth partial products: registers the set, then adds
// PP_PER_CYCLE of them per cycle into a wrapping accumulator and offers the sum downstream.
module booth_pp_accumulator #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned PP_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    booth_pp_accumulator_if.slave   bus
);

    localparam int unsigned NumPp  = 8;
    localparam int unsigned NumGrp = NumPp / PP_PER_CYCLE;
    localparam int unsigned CntW   = (NumGrp > 1) ? $clog2(NumGrp) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NumGrp - 1);

    generate
        if (!(PP_PER_CYCLE == 1 || PP_PER_CYCLE == 2 || PP_PER_CYCLE == 4 ||
              PP_PER_CYCLE == 8)) begin : g_bad_pp_per_cycle
            $error("booth_pp_accumulator: PP_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_bank [NumPp];
    logic [WIDTH-1:0] r_acc;
    logic [CntW-1:0]  r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_product;
    logic             r_busy;

    logic [2:0]       w_base;
    logic [WIDTH-1:0] w_grp_sum;
    logic [WIDTH-1:0] w_acc_next;

    // Group r_cnt covers bank entries [r_cnt*K .. r_cnt*K+K-1]; 3-bit index wraps cleanly.
    always_comb begin
        w_base    = 3'(int'(r_cnt) * int'(PP_PER_CYCLE));
        w_grp_sum = '0;
        for (int j = 0; j < int'(PP_PER_CYCLE); j++) begin
            w_grp_sum = w_grp_sum + r_bank[w_base + 3'(j)];
        end
        w_acc_next = r_acc + w_grp_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_bank[0]  <= bus.pp1;
                        r_bank[1]  <= bus.pp2;
                        r_bank[2]  <= bus.pp3;
                        r_bank[3]  <= bus.pp4;
                        r_bank[4]  <= bus.pp5;
                        r_bank[5]  <= bus.pp6;
                        r_bank[6]  <= bus.pp7;
                        r_bank[7]  <= bus.pp8;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= StAccum;
                    end
                end
                StAccum: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CntLast) begin
                        // Product is loaded from the final sum so it is valid with out_valid.
                        r_product   <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench: the driver pushes the expected product on each accept, a negedge monitor
// pops and compares on every output handshake and also checks accept-to-valid latency.
module tb_booth_pp_accumulator;

    parameter int unsigned K = 1;
    localparam int LAT = 8 / int'(K);

    typedef logic [7:0][31:0] pp_bank_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   rdy_mode = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [31:0] exp_q[$];
    logic prev_ov = 1'b0;
    logic prev_hs = 1'b0;

    booth_pp_accumulator_if #(.WIDTH(32)) bus ();

    booth_pp_accumulator #(
        .WIDTH        (32),
        .PP_PER_CYCLE (K)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Radix-4 Booth recoding of Q, one signed multiple of M per digit, shifted by 2*i.
    function automatic pp_bank_t booth_pps(input logic [15:0] m, input logic [15:0] q);
        pp_bank_t    b;
        logic [2:0]  trip;
        logic [31:0] mx;
        logic [31:0] v;
        mx = {{16{m[15]}}, m};
        for (int i = 0; i < 8; i++) begin
            trip = {q[2*i+1], q[2*i], (i == 0) ? 1'b0 : q[2*i-1]};
            case (trip)
                3'b001, 3'b010: v = mx;
                3'b011:         v = mx << 1;
                3'b100:         v = -(mx << 1);
                3'b101, 3'b110: v = -mx;
                default:        v = '0;
            endcase
            b[i] = v << (2 * i);
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic drive_pps(input logic [15:0] m, input logic [15:0] q);
        pp_bank_t b;
        b = booth_pps(m, q);
        bus.pp1 = b[0]; bus.pp2 = b[1]; bus.pp3 = b[2]; bus.pp4 = b[3];
        bus.pp5 = b[4]; bus.pp6 = b[5]; bus.pp7 = b[6]; bus.pp8 = b[7];
    endtask

    // Returns just after the accepting edge; PP inputs are scrambled afterwards on purpose.
    task automatic send(input logic [15:0] m, input logic [15:0] q, input logic [31:0] exp,
                        input bit expect_out, input int gap);
        bit done;
        done = 0;
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        drive_pps(m, q);
        bus.in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (expect_out) exp_q.push_back(exp);
                @(posedge clk); #1;
                acc_cyc      = cyc;
                bus.in_valid = 1'b0;
                drive_pps(16'h5A5A, 16'hA5A5);
                done = 1;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready never seen, expected accept within 100 cycles");
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        rdy_mode = 1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid && !bus.busy) done = 1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && !prev_ov) chk("latency", 32'(cyc - acc_cyc), 32'(LAT));
            if (prev_hs) chk("valid_drops_after_handshake", {31'd0, bus.out_valid}, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got 0x%08h, expected no output",
                             bus.product);
                end else begin
                    chk("product", bus.product, exp_q.pop_front());
                end
            end
        end
        prev_ov <= bus.out_valid && !rst;
        prev_hs <= bus.out_valid && bus.out_ready && !rst;
    end

    logic [15:0] rm;
    logic [15:0] rq;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_pps(16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_product",   bus.product,            32'd0);
        chk("reset_busy",      {31'd0, bus.busy},      32'd0);

        rdy_mode = 1;
        send(16'd18, 16'd999, 32'd17982, 1, 0);
        drain();
        send(16'hF6F9, 16'd11111, -32'sd25677521, 1, 0);
        drain();
        send(16'hFFFF, 16'hFFFF, 32'd1, 1, 0);
        drain();
        send(16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1, 0);
        drain();
        send(16'h8000, 16'h8000, 32'h40000000, 1, 0);
        drain();

        // Back-pressure: result must sit unchanged and stray in_valid must be ignored.
        rdy_mode = 0;
        @(posedge clk);
        send(16'd300, 16'hFF9C, -32'sd30000, 1, 0);
        for (int t = 0; t < 50 && !bus.out_valid; t++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.in_valid = (i == 1 || i == 2);
            drive_pps(16'd3, 16'd3);
            @(negedge clk);
            chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_product",   bus.product,            -32'sd30000);
            chk("hold_in_ready",  {31'd0, bus.in_ready},  32'd0);
            chk("hold_busy",      {31'd0, bus.busy},      32'd1);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();

        // Abort in the 4th post-accept cycle; the result must never appear.
        rdy_mode = 0;
        @(posedge clk);
        send(16'd5, 16'd7, 32'd35, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_product",   bus.product,            32'd0);
        rdy_mode = 1;
        send(16'd1, 16'd11111, 32'd11111, 1, 0);
        drain();

        rdy_mode = 2;
        for (int n = 0; n < 1000; n++) begin
            rm = 16'($urandom);
            rq = 16'($urandom);
            send(rm, rq, 32'(int'($signed(rm)) * int'($signed(rq))), 1,
                 int'($urandom_range(0, 3)));
        end
        drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
